// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: control/data bundle of the two-stage pipelined datapath.
//   master : the controller that issues control words (CTRWRD, in_valid,
//            STALL, Cin) and returns memory read data (Din).
//   slave  : the datapath, which returns the memory address (Adrout), the
//            write data (Dout), out_valid and the V/C/N/Z status flags.
// CTRWRD layout, MSB first: {DA[AW], AA[AW], BA[AW], MB, FS[4], MD, RW}.
interface pipe_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) ();
  localparam int AW = $clog2(NREGS);
  localparam int CW = 3 * AW + 7;

  logic [CW-1:0]    CTRWRD;
  logic             in_valid;
  logic             STALL;
  logic [WIDTH-1:0] Cin;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Adrout;
  logic [WIDTH-1:0] Dout;
  logic             out_valid;
  logic             V;
  logic             C;
  logic             N;
  logic             Z;

  modport master (
    output CTRWRD, in_valid, STALL, Cin, Din,
    input  Adrout, Dout, out_valid, V, C, N, Z
  );

  modport slave (
    input  CTRWRD, in_valid, STALL, Cin, Din,
    output Adrout, Dout, out_valid, V, C, N, Z
  );
endinterface

// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage pipelined datapath.
//   Stage 1 decodes CTRWRD, reads A/B from the register file (or the
//   stage-2 result when it targets the same register) and applies the
//   MB constant mux; A and B are registered as Adrout and Dout.
//   Stage 2 runs the function unit on the registered operands, picks the
//   ALU result or Din, writes the register file and updates V/C/N/Z.
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RESET - synchronous active-high reset, dominates STALL
//   bus   - pipe_datapath_if.slave (control word, handshake, data, flags)
module pipe_datapath #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int R0_ZERO = 0
) (
  input logic             CLK,
  input logic             RESET,
  pipe_datapath_if.slave  bus
);
  localparam int AW       = $clog2(NREGS);
  localparam int CW       = 3 * AW + 7;
  localparam bit ZERO_REG = (R0_ZERO != 0);

  // Function unit: returns {overflow, carry, result}. Codes 0-7 are all
  // additions of A with a selected addend and carry-in, so a single adder
  // covers them; codes 8-F are bitwise/shift operations with C=V=0.
  function automatic logic [WIDTH+1:0] alu(input logic [3:0] f,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] addend;
    logic             cin_bit;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
    addend  = {WIDTH{1'b0}};
    cin_bit = 1'b0;
    sum     = {(WIDTH+1){1'b0}};
    res     = {WIDTH{1'b0}};
    cy      = 1'b0;
    ov      = 1'b0;
    if (f[3] == 1'b0) begin
      case (f[2:0])
        3'd0:    begin addend = {WIDTH{1'b0}}; cin_bit = 1'b0; end
        3'd1:    begin addend = {WIDTH{1'b0}}; cin_bit = 1'b1; end
        3'd2:    begin addend = b;             cin_bit = 1'b0; end
        3'd3:    begin addend = b;             cin_bit = 1'b1; end
        3'd4:    begin addend = ~b;            cin_bit = 1'b0; end
        3'd5:    begin addend = ~b;            cin_bit = 1'b1; end
        3'd6:    begin addend = {WIDTH{1'b1}}; cin_bit = 1'b0; end
        3'd7:    begin addend = {WIDTH{1'b0}}; cin_bit = 1'b0; end
        default: begin addend = {WIDTH{1'b0}}; cin_bit = 1'b0; end
      endcase
      sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin_bit};
      res = sum[WIDTH-1:0];
      cy  = sum[WIDTH];
      // Signed overflow: like-signed inputs produced an opposite-signed sum.
      ov  = (a[WIDTH-1] == addend[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (f[2:0])
        3'd0:    res = a & b;
        3'd1:    res = a | b;
        3'd2:    res = a ^ b;
        3'd3:    res = ~a;
        3'd4:    res = b;
        3'd5:    res = {1'b0, b[WIDTH-1:1]};
        3'd6:    res = {b[WIDTH-2:0], 1'b0};
        3'd7:    res = b;
        default: res = {WIDTH{1'b0}};
      endcase
    end
    return {ov, cy, res};
  endfunction

  // Control word fields
  logic [AW-1:0] da;
  logic [AW-1:0] aa;
  logic [AW-1:0] ba;
  logic          mb;
  logic [3:0]    fs;
  logic          md;
  logic          rw;

  assign da = bus.CTRWRD[CW-1 -: AW];
  assign aa = bus.CTRWRD[CW-AW-1 -: AW];
  assign ba = bus.CTRWRD[CW-2*AW-1 -: AW];
  assign mb = bus.CTRWRD[6];
  assign fs = bus.CTRWRD[5:2];
  assign md = bus.CTRWRD[1];
  assign rw = bus.CTRWRD[0];

  // State
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [AW-1:0]    ex_da;
  logic [3:0]       ex_fs;
  logic             ex_md;
  logic             ex_rw;
  logic             ex_valid;
  logic             flag_v;
  logic             flag_c;
  logic             flag_n;
  logic             flag_z;

  // Stage 2 combinational results
  logic [WIDTH-1:0] ex_f;
  logic             ex_cy;
  logic             ex_ov;
  logic [WIDTH-1:0] wb_data;
  logic             wb_en;

  // Stage 1 combinational operand selection
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  // Execute stage: function unit, write-back mux and write qualification.
  // A write to register 0 is suppressed when it is hard-wired to zero, which
  // also keeps such a write out of the forwarding path.
  always_comb begin
    ex_ov   = 1'b0;
    ex_cy   = 1'b0;
    ex_f    = {WIDTH{1'b0}};
    {ex_ov, ex_cy, ex_f} = alu(ex_fs, op_a, op_b);
    wb_data = ex_md ? bus.Din : ex_f;
    wb_en   = ex_valid && ex_rw && !(ZERO_REG && (ex_da == {AW{1'b0}}));
  end

  // Fetch stage: register read with bypass from execute, then the MB mux.
  always_comb begin
    rd_a   = (ZERO_REG && (aa == {AW{1'b0}})) ? {WIDTH{1'b0}} : regs[aa];
    rd_b   = (ZERO_REG && (ba == {AW{1'b0}})) ? {WIDTH{1'b0}} : regs[ba];
    fwd_a  = wb_en && (ex_da == aa);
    fwd_b  = wb_en && (ex_da == ba);
    a_next = fwd_a ? wb_data : rd_a;
    b_next = mb ? bus.Cin : (fwd_b ? wb_data : rd_b);
  end

  // Pipeline registers, register file and flags; STALL freezes everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
      op_a     <= {WIDTH{1'b0}};
      op_b     <= {WIDTH{1'b0}};
      ex_da    <= {AW{1'b0}};
      ex_fs    <= 4'd0;
      ex_md    <= 1'b0;
      ex_rw    <= 1'b0;
      ex_valid <= 1'b0;
      flag_v   <= 1'b0;
      flag_c   <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else if (!bus.STALL) begin
      if (wb_en) begin
        regs[ex_da] <= wb_data;
      end
      // Bubbles leave the flags untouched.
      if (ex_valid) begin
        flag_v <= ex_ov;
        flag_c <= ex_cy;
        flag_n <= ex_f[WIDTH-1];
        flag_z <= (ex_f == {WIDTH{1'b0}});
      end
      ex_valid <= bus.in_valid;
      if (bus.in_valid) begin
        op_a  <= a_next;
        op_b  <= b_next;
        ex_da <= da;
        ex_fs <= fs;
        ex_md <= md;
        ex_rw <= rw;
      end
    end
  end

  assign bus.Adrout    = op_a;
  assign bus.Dout      = op_b;
  assign bus.out_valid = ex_valid;
  assign bus.V         = flag_v;
  assign bus.C         = flag_c;
  assign bus.N         = flag_n;
  assign bus.Z         = flag_z;
endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: self-checking bench for pipe_datapath (WIDTH=16,
// NREGS=8, R0_ZERO=1). The reference executes accepted control words one
// at a time, in order, against an array register file, which is the
// behaviour the bypass network must reproduce.
module tb_pipe_datapath;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 3 * AW + 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_datapath_if #(.WIDTH(W), .NREGS(N)) bus ();

  pipe_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [W-1:0]  mregs [N];
  logic          mv, mc, mn, mz;
  logic          pend_valid;
  logic [AW-1:0] p_da;
  logic [3:0]    p_fs;
  logic          p_md, p_rw;
  logic [W-1:0]  p_a, p_b, p_din;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [AW-1:0] da, input logic [AW-1:0] aa,
                                       input logic [AW-1:0] ba, input logic mb,
                                       input logic [3:0] fs, input logic md, input logic rw);
    return {da, aa, ba, mb, fs, md, rw};
  endfunction

  // Reference function unit: returns {V, C, F}. Carry from unsigned
  // arithmetic, overflow from the true signed result leaving the range.
  function automatic logic [W+1:0] ref_op(input logic [3:0] fs, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] addend;
    longint       ci, ur, sr, smax, smin;
    logic [W-1:0] f;
    logic         c, v;
    addend = 16'h0000; ci = 0; c = 1'b0; v = 1'b0; f = 16'h0000;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (fs < 4'd8) begin
      case (fs)
        4'd1: ci = 1;
        4'd2: addend = b;
        4'd3: begin addend = b; ci = 1; end
        4'd4: addend = ~b;
        4'd5: begin addend = ~b; ci = 1; end
        4'd6: addend = 16'hFFFF;
        default: addend = 16'h0000;
      endcase
      ur = longint'(a) + longint'(addend) + ci;
      f  = ur[W-1:0];
      c  = ur[W];
      sr = longint'($signed(a)) + longint'($signed(addend)) + ci;
      v  = (sr > smax) || (sr < smin);
    end else begin
      case (fs)
        4'h8: f = a & b;
        4'h9: f = a | b;
        4'hA: f = a ^ b;
        4'hB: f = ~a;
        4'hD: f = b / 2;
        4'hE: f = b * 2;
        default: f = b;
      endcase
    end
    return {v, c, f};
  endfunction

  // One clock: drive at negedge, advance the reference at posedge, check #1 later.
  task automatic step(input bit stall, input bit valid, input logic [CW-1:0] ctrl,
                      input logic [W-1:0] cin, input logic [W-1:0] din);
    logic [W+1:0]  r;
    logic [W-1:0]  d;
    logic [AW-1:0] da, aa, ba;
    logic          mb, md, rw;
    logic [3:0]    fs;
    @(negedge clk);
    bus.STALL    = stall;
    bus.in_valid = valid;
    bus.CTRWRD   = ctrl;
    bus.Cin      = cin;
    bus.Din      = pend_valid ? p_din : W'($urandom);
    @(posedge clk);
    if (!stall) begin
      if (pend_valid) begin
        r = ref_op(p_fs, p_a, p_b);
        d = p_md ? p_din : r[W-1:0];
        if (p_rw && (p_da != 3'd0)) mregs[p_da] = d;
        mv = r[W+1];
        mc = r[W];
        mn = r[W-1];
        mz = (r[W-1:0] == 16'h0000);
      end
      pend_valid = valid;
      if (valid) begin
        {da, aa, ba, mb, fs, md, rw} = ctrl;
        p_a   = (aa == 3'd0) ? 16'h0000 : mregs[aa];
        p_b   = mb ? cin : ((ba == 3'd0) ? 16'h0000 : mregs[ba]);
        p_da  = da;
        p_fs  = fs;
        p_md  = md;
        p_rw  = rw;
        p_din = din;
      end
    end
    #1;
    check_val("out_valid", bus.out_valid, pend_valid);
    if (pend_valid) begin
      check_val("Adrout", bus.Adrout, p_a);
      check_val("Dout", bus.Dout, p_b);
    end
    check_val("flags_VCNZ", {bus.V, bus.C, bus.N, bus.Z}, {mv, mc, mn, mz});
  endtask

  task automatic do_reset(input bit stall);
    @(negedge clk);
    rst          = 1'b1;
    bus.STALL    = stall;
    bus.in_valid = 1'b1;
    bus.CTRWRD   = CW'($urandom);
    @(posedge clk);
    for (int i = 0; i < N; i++) mregs[i] = 16'h0000;
    {mv, mc, mn, mz} = 4'b0000;
    pend_valid = 1'b0;
    #1;
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_Adrout", bus.Adrout, 16'h0000);
    check_val("rst_Dout", bus.Dout, 16'h0000);
    check_val("rst_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b0000);
    @(negedge clk);
    rst          = 1'b0;
    bus.STALL    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    bus.CTRWRD = 16'h0000; bus.in_valid = 1'b0; bus.STALL = 1'b0;
    bus.Cin = 16'h0000; bus.Din = 16'h0000;
    pend_valid = 1'b0;
    do_reset(1'b0);

    // Idle, then probe every register with FS=0
    bubble();
    bubble();
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, mk(3'd0, AW'(i), AW'(i), 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    bubble();

    // Load then dependent add through the bypass
    step(1'b0, 1'b1, mk(3'd1, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h0005, 16'h0000);
    step(1'b0, 1'b1, mk(3'd2, 3'd1, 3'd1, 1'b0, 4'h2, 1'b0, 1'b1), 16'h0000, 16'h0000);
    bubble();
    check_val("add_chain_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b0000);
    step(1'b0, 1'b1, mk(3'd0, 3'd2, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    check_val("add_chain_R2", bus.Adrout, 16'h000A);

    // Signed overflow, then A + ~B + 1 giving zero with carry
    step(1'b0, 1'b1, mk(3'd1, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h7FFF, 16'h0000);
    step(1'b0, 1'b1, mk(3'd2, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h0001, 16'h0000);
    step(1'b0, 1'b1, mk(3'd3, 3'd1, 3'd2, 1'b0, 4'h2, 1'b0, 1'b1), 16'h0000, 16'h0000);
    bubble();
    check_val("ovf_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b1010);
    step(1'b0, 1'b1, mk(3'd4, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h1234, 16'h0000);
    step(1'b0, 1'b1, mk(3'd5, 3'd4, 3'd4, 1'b0, 4'h5, 1'b0, 1'b1), 16'h0000, 16'h0000);
    bubble();
    check_val("sub_zero_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b0101);

    // Memory load: R6 <- Din, flags follow F (= A = R1)
    step(1'b0, 1'b1, mk(3'd6, 3'd1, 3'd0, 1'b0, 4'h0, 1'b1, 1'b1), 16'h0000, 16'hBEEF);
    check_val("mem_addr", bus.Adrout, 16'h7FFF);
    bubble();
    check_val("mem_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b0000);
    step(1'b0, 1'b1, mk(3'd0, 3'd6, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    check_val("mem_R6", bus.Adrout, 16'hBEEF);

    // Shift left of 0x8000 drops the bit without setting carry
    step(1'b0, 1'b1, mk(3'd5, 3'd0, 3'd0, 1'b1, 4'hE, 1'b0, 1'b1), 16'h8000, 16'h0000);
    bubble();
    check_val("shl_flags", {bus.V, bus.C, bus.N, bus.Z}, 4'b0001);

    // R0 is hard-wired: write ignored, not forwarded
    step(1'b0, 1'b1, mk(3'd0, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'hFFFF, 16'h0000);
    step(1'b0, 1'b1, mk(3'd3, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1), 16'h0000, 16'h0000);
    check_val("r0_nofwd", bus.Adrout, 16'h0000);
    bubble();

    // Stall three cycles in the middle of a dependent chain
    step(1'b0, 1'b1, mk(3'd3, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h0003, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, CW'($urandom), W'($urandom), 16'h0000);
    step(1'b0, 1'b1, mk(3'd4, 3'd3, 3'd3, 1'b0, 4'h2, 1'b0, 1'b1), 16'h0000, 16'h0000);
    bubble();
    step(1'b0, 1'b1, mk(3'd0, 3'd4, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    check_val("stall_chain_R4", bus.Adrout, 16'h0006);

    // Reset during a stall discards the in-flight write to R5
    step(1'b0, 1'b1, mk(3'd5, 3'd0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b1), 16'h1111, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    do_reset(1'b1);
    step(1'b0, 1'b1, mk(3'd0, 3'd5, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    check_val("rst_stall_R5", bus.Adrout, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      else step(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 80),
                CW'($urandom), W'($urandom), W'($urandom));
    end

    // Final sweep of the register file
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, mk(3'd0, AW'(i), AW'(i), 1'b0, 4'h0, 1'b0, 1'b0), 16'h0000, 16'h0000);
    bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
